// File: rtl/motion_estimator_param_if.sv
// Bus bundle between the motion estimator and its requester/memories:
// start request, reference/window read ports and the search result.
interface motion_estimator_param_if #(
  parameter int PW  = 8,
  parameter int N   = 16,
  parameter int P   = 8,
  parameter int NPE = 16
);
  localparam int W    = N + 2 * P;
  localparam int SADW = PW + 2 * $clog2(N);
  localparam int MVW  = $clog2(2 * P) + 1;

  logic                     start;
  logic [$clog2(N*N)-1:0]   addr_r;
  logic [PW-1:0]            r_data;
  logic [$clog2(W*W)-1:0]   addr_s;
  logic [NPE*PW-1:0]        s_data;
  logic                     rd_en;
  logic                     busy;
  logic                     done;
  logic [MVW-1:0]           motion_x;
  logic [MVW-1:0]           motion_y;
  logic [SADW-1:0]          best_sad;

  modport master (
    output start, r_data, s_data,
    input  addr_r, addr_s, rd_en, busy, done, motion_x, motion_y, best_sad
  );

  modport slave (
    input  start, r_data, s_data,
    output addr_r, addr_s, rd_en, busy, done, motion_x, motion_y, best_sad
  );
endinterface

// File: rtl/motion_estimator_param.sv
// Full-search block motion estimator. Candidates are processed in groups of
// NPE horizontally adjacent displacements sharing one dy; each group streams
// the reference block once, NPE PEs accumulate SADs, then the PEs are compared
// one per cycle against the running best (strict less-than, so ties keep the
// earliest candidate in scan order).
module motion_estimator_param #(
  parameter int PW  = 8,
  parameter int N   = 16,
  parameter int P   = 8,
  parameter int NPE = 16
) (
  input logic clk,
  input logic reset,
  motion_estimator_param_if.slave bus
);
  localparam int W    = N + 2 * P;
  localparam int SADW = PW + 2 * $clog2(N);
  localparam int MVW  = $clog2(2 * P) + 1;
  localparam int G    = (2 * P) * (2 * P) / NPE;
  localparam int GPR  = (2 * P) / NPE;
  localparam int AWR  = $clog2(N * N);
  localparam int AWS  = $clog2(W * W);
  localparam int IW   = $clog2(2 * P);
  localparam int GW   = (G > 1) ? $clog2(G) : 1;
  localparam int CW   = (NPE > 1) ? $clog2(NPE) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, CMP, DONE} stateT;
  stateT state, stateNext;

  logic [AWR-1:0]  pixCnt;
  logic            drainCnt;
  logic [CW-1:0]   cmpIdx;
  logic [GW-1:0]   grp;
  logic [IW-1:0]   rowBase;
  logic [IW-1:0]   colBase;
  logic            lastPix, lastCmp, lastGroup, enterFetch;
  logic            v1, v2;
  logic [PW-1:0]   absDiff [NPE];
  logic [SADW-1:0] acc [NPE];
  logic [SADW-1:0] bestSadW, candSad, finalSad;
  logic [IW-1:0]   bestXW, bestYW, candX, finalX, finalY;
  logic            candBetter;

  // Window offsets of the current group: rowBase = P+dy, colBase = P+dx0.
  assign rowBase    = IW'(int'(grp) / GPR);
  assign colBase    = IW'((int'(grp) % GPR) * NPE);
  assign lastPix    = (pixCnt == AWR'(N * N - 1));
  assign lastCmp    = (cmpIdx == CW'(NPE - 1));
  assign lastGroup  = (grp == GW'(G - 1));
  assign enterFetch = (state != FETCH) && (stateNext == FETCH);

  // The PE under comparison and the best including this cycle's decision.
  assign candSad    = acc[cmpIdx];
  assign candX      = colBase + IW'(cmpIdx);
  assign candBetter = (state == CMP) && (candSad < bestSadW);
  assign finalSad   = candBetter ? candSad : bestSadW;
  assign finalX     = candBetter ? candX : bestXW;
  assign finalY     = candBetter ? rowBase : bestYW;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state logic and the combinational memory/status outputs.
  always_comb begin
    stateNext   = state;
    bus.rd_en   = 1'b0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.addr_r  = '0;
    bus.addr_s  = '0;
    case (state)
      IDLE:  if (bus.start) stateNext = FETCH;
      FETCH: begin
        bus.rd_en  = 1'b1;
        bus.busy   = 1'b1;
        bus.addr_r = pixCnt;
        bus.addr_s = AWS'((int'(rowBase) + int'(pixCnt) / N) * W
                          + int'(colBase) + int'(pixCnt) % N);
        if (lastPix) stateNext = DRAIN;
      end
      DRAIN: begin
        bus.busy = 1'b1;
        if (drainCnt) stateNext = CMP;
      end
      CMP: begin
        bus.busy = 1'b1;
        if (lastCmp) stateNext = lastGroup ? DONE : FETCH;
      end
      DONE: begin
        bus.done  = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Pixel, drain, compare and group sequencing counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      pixCnt   <= '0;
      drainCnt <= 1'b0;
      cmpIdx   <= '0;
      grp      <= '0;
    end else begin
      case (state)
        IDLE: begin
          pixCnt <= '0;
          grp    <= '0;
        end
        FETCH: begin
          pixCnt   <= pixCnt + AWR'(1);
          drainCnt <= 1'b0;
        end
        DRAIN: begin
          drainCnt <= 1'b1;
          cmpIdx   <= '0;
        end
        CMP: begin
          cmpIdx <= cmpIdx + CW'(1);
          pixCnt <= '0;
          if (lastCmp) grp <= grp + GW'(1);
        end
        default: ;
      endcase
    end
  end

  // PE array: register |ref - lane k|, then accumulate it two cycles after the read.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      for (int k = 0; k < NPE; k++) begin
        absDiff[k] <= '0;
        acc[k]     <= '0;
      end
    end else begin
      v1 <= (state == FETCH);
      v2 <= v1;
      for (int k = 0; k < NPE; k++) begin
        if (bus.r_data >= bus.s_data[k*PW +: PW])
          absDiff[k] <= bus.r_data - bus.s_data[k*PW +: PW];
        else
          absDiff[k] <= bus.s_data[k*PW +: PW] - bus.r_data;
        if (enterFetch)
          acc[k] <= '0;
        else if (v2)
          acc[k] <= acc[k] + SADW'(absDiff[k]);
      end
    end
  end

  // Working best and the published result, which only changes on entry to DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      bestSadW     <= '0;
      bestXW       <= '0;
      bestYW       <= '0;
      bus.motion_x <= '0;
      bus.motion_y <= '0;
      bus.best_sad <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        bestSadW <= '1;
        bestXW   <= '0;
        bestYW   <= '0;
      end else if (candBetter) begin
        bestSadW <= candSad;
        bestXW   <= candX;
        bestYW   <= rowBase;
      end
      if (state == CMP && lastCmp && lastGroup) begin
        bus.motion_x <= MVW'(finalX) - MVW'(P);
        bus.motion_y <= MVW'(finalY) - MVW'(P);
        bus.best_sad <= finalSad;
      end
    end
  end
endmodule

// File: tb/tb_motion_estimator_param.sv
// Self-checking bench: a small configuration (N=4, P=2, NPE=4) for directed
// and random cases, plus the default configuration on random data, both
// compared against a plain full-search software model.
module tb_motion_estimator_param;
  localparam int SN = 4, SP = 2, SNPE = 4, SW = SN + 2 * SP;
  localparam int BN = 16, BP = 8, BNPE = 16, BW = BN + 2 * BP;
  localparam int SMVW = 3, BMVW = 5;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;
  int   refMem [2][256];
  int   winMem [2][1024];

  motion_estimator_param_if #(.PW(8), .N(SN), .P(SP), .NPE(SNPE)) busS ();
  motion_estimator_param_if #(.PW(8), .N(BN), .P(BP), .NPE(BNPE)) busB ();

  motion_estimator_param #(.PW(8), .N(SN), .P(SP), .NPE(SNPE)) dutS (
    .clk(clk), .reset(reset), .bus(busS)
  );
  motion_estimator_param #(.PW(8), .N(BN), .P(BP), .NPE(BNPE)) dutB (
    .clk(clk), .reset(reset), .bus(busB)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memories for the small instance.
  always @(posedge clk) begin
    if (busS.rd_en) begin
      busS.r_data <= 8'(refMem[0][int'(busS.addr_r)]);
      for (int k = 0; k < SNPE; k++)
        busS.s_data[k*8 +: 8] <= 8'(winMem[0][int'(busS.addr_s) + k]);
    end
  end

  // Synchronous-read memories for the default-size instance.
  always @(posedge clk) begin
    if (busB.rd_en) begin
      busB.r_data <= 8'(refMem[1][int'(busB.addr_r)]);
      for (int k = 0; k < BNPE; k++)
        busB.s_data[k*8 +: 8] <= 8'(winMem[1][int'(busB.addr_s) + k]);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] mvEnc(input int d, input int w);
    return 32'(d) & ((32'd1 << w) - 32'd1);
  endfunction

  // Exhaustive search straight from the definition: first strict minimum in scan order.
  function automatic void refSearch(input int sel, input int n, input int p,
                                    output int bx, output int by, output int bs);
    int w, sad, d;
    w  = n + 2 * p;
    bs = 32'h7fffffff;
    bx = -p;
    by = -p;
    for (int dy = -p; dy < p; dy++) begin
      for (int dx = -p; dx < p; dx++) begin
        sad = 0;
        for (int i = 0; i < n; i++) begin
          for (int j = 0; j < n; j++) begin
            d = refMem[sel][i*n + j] - winMem[sel][(p + dy + i) * w + (p + dx + j)];
            sad += (d < 0) ? -d : d;
          end
        end
        if (sad < bs) begin
          bs = sad;
          bx = dx;
          by = dy;
        end
      end
    end
  endfunction

  task automatic fillRandom(input int sel, input int n, input int p);
    for (int i = 0; i < n * n; i++) refMem[sel][i] = int'($urandom_range(0, 255));
    for (int i = 0; i < (n + 2*p) * (n + 2*p); i++) winMem[sel][i] = int'($urandom_range(0, 255));
  endtask

  task automatic fillPlanted(input int sel, input int n, input int p, input int dx, input int dy,
                             input int background);
    int w;
    w = n + 2 * p;
    for (int i = 0; i < w * w; i++) winMem[sel][i] = background;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        refMem[sel][i*n + j] = int'($urandom_range(0, 200));
        winMem[sel][(p + dy + i) * w + (p + dx + j)] = refMem[sel][i*n + j];
      end
    end
  endtask

  task automatic fillConst(input int sel, input int n, input int p, input int rv, input int wv);
    for (int i = 0; i < n * n; i++) refMem[sel][i] = rv;
    for (int i = 0; i < (n + 2*p) * (n + 2*p); i++) winMem[sel][i] = wv;
  endtask

  // Pulse start for one cycle on the small instance; returns #1 after the accepting edge.
  task automatic applyStimulus();
    busS.start = 1'b1;
    @(posedge clk); #1;
    busS.start = 1'b0;
  endtask

  // Run one small search, optionally re-pulsing start at cycle pokeAt, and check it.
  task automatic runSearchS(input string tag, input int pokeAt);
    int cycles, rdCount, addrBad, busyBad, bx, by, bs;
    cycles = -1; rdCount = 0; addrBad = 0; busyBad = 0;
    applyStimulus();
    checkOutput({tag, ".busyRise"}, 32'(busS.busy), 32'd1);
    for (int c = 0; c <= 200; c++) begin
      if (busS.done) begin
        cycles = c;
        break;
      end
      if (!busS.busy) busyBad++;
      if (busS.rd_en) rdCount++;
      else if (busS.addr_r != 0 || busS.addr_s != 0) addrBad++;
      busS.start = (c == pokeAt);
      @(posedge clk); #1;
    end
    busS.start = 1'b0;
    refSearch(0, SN, SP, bx, by, bs);
    checkOutput({tag, ".cycles"}, 32'(cycles), 32'd88);
    checkOutput({tag, ".rdCycles"}, 32'(rdCount), 32'd64);
    checkOutput({tag, ".addrIdle"}, 32'(addrBad), 32'd0);
    checkOutput({tag, ".busyHeld"}, 32'(busyBad), 32'd0);
    checkOutput({tag, ".mx"}, 32'(busS.motion_x), mvEnc(bx, SMVW));
    checkOutput({tag, ".my"}, 32'(busS.motion_y), mvEnc(by, SMVW));
    checkOutput({tag, ".sad"}, 32'(busS.best_sad), 32'(bs));
    @(posedge clk); #1;
    checkOutput({tag, ".doneLow"}, 32'(busS.done), 32'd0);
    checkOutput({tag, ".sadHeld"}, 32'(busS.best_sad), 32'(bs));
  endtask

  // Run one default-size search and compare with the model.
  task automatic runSearchB(input string tag);
    int cycles, bx, by, bs;
    cycles = -1;
    busB.start = 1'b1;
    @(posedge clk); #1;
    busB.start = 1'b0;
    for (int c = 0; c <= 5000; c++) begin
      if (busB.done) begin
        cycles = c;
        break;
      end
      @(posedge clk); #1;
    end
    refSearch(1, BN, BP, bx, by, bs);
    checkOutput({tag, ".cycles"}, 32'(cycles), 32'd4384);
    checkOutput({tag, ".mx"}, 32'(busB.motion_x), mvEnc(bx, BMVW));
    checkOutput({tag, ".my"}, 32'(busB.motion_y), mvEnc(by, BMVW));
    checkOutput({tag, ".sad"}, 32'(busB.best_sad), 32'(bs));
    @(posedge clk); #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, ".busy"}, 32'(busS.busy), 32'd0);
    checkOutput({tag, ".done"}, 32'(busS.done), 32'd0);
    checkOutput({tag, ".rdEn"}, 32'(busS.rd_en), 32'd0);
    checkOutput({tag, ".addrR"}, 32'(busS.addr_r), 32'd0);
    checkOutput({tag, ".addrS"}, 32'(busS.addr_s), 32'd0);
    checkOutput({tag, ".mx"}, 32'(busS.motion_x), 32'd0);
    checkOutput({tag, ".my"}, 32'(busS.motion_y), 32'd0);
    checkOutput({tag, ".sad"}, 32'(busS.best_sad), 32'd0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    busS.start = 1'b0;
    busB.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] planted match at dx=+1, dy=-1");
    fillPlanted(0, SN, SP, 1, -1, 255);
    runSearchS("planted", -1);
    checkOutput("planted.mxConst", 32'(busS.motion_x), 32'h1);
    checkOutput("planted.myConst", 32'(busS.motion_y), 32'h7);
    checkOutput("planted.sadConst", 32'(busS.best_sad), 32'd0);

    $display("[TB] all pixels equal, tie rule");
    begin
      int v;
      v = int'($urandom_range(0, 255));
      fillConst(0, SN, SP, v, v);
    end
    runSearchS("ties", -1);
    checkOutput("ties.mxConst", 32'(busS.motion_x), 32'h6);
    checkOutput("ties.myConst", 32'(busS.motion_y), 32'h6);
    checkOutput("ties.sadConst", 32'(busS.best_sad), 32'd0);

    $display("[TB] maximum SAD");
    fillConst(0, SN, SP, 255, 0);
    runSearchS("maxSad", -1);
    checkOutput("maxSad.sadConst", 32'(busS.best_sad), 32'd4080);

    $display("[TB] random data, back-to-back starts, mid-search start");
    for (int t = 0; t < 3; t++) begin
      fillRandom(0, SN, SP);
      runSearchS($sformatf("rand%0d", t), (t == 1) ? 30 : -1);
    end

    $display("[TB] reset mid-search together with start");
    fillRandom(0, SN, SP);
    applyStimulus();
    repeat (40) begin
      @(posedge clk); #1;
    end
    reset      = 1'b1;
    busS.start = 1'b1;
    @(posedge clk); #1;
    checkResetState("midReset");
    reset      = 1'b0;
    busS.start = 1'b0;
    @(posedge clk); #1;
    checkOutput("midReset.stayIdle", 32'(busS.busy), 32'd0);
    fillRandom(0, SN, SP);
    runSearchS("afterReset", -1);

    $display("[TB] default configuration");
    fillRandom(1, BN, BP);
    runSearchB("bigRand");
    fillRandom(1, BN, BP);
    for (int i = 0; i < BN; i++)
      for (int j = 0; j < BN; j++)
        winMem[1][(BP - 3 + i) * BW + (BP + 5 + j)] = refMem[1][i*BN + j];
    runSearchB("bigPlanted");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
